hazard_unit_mdu: RTL and testbench

Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline. It keeps the existing forwarding, load-use stall and branch stall functions, with register-0 qualification applied everywhere, and adds three things: decode-stage flush for taken branches and jumps, a multi-cycle multiply/divide (MDU) busy scoreboard that stalls dependent HI/LO accesses, and a saturating stall-cycle performance counter. It sits beside the datapath and drives the F/D/E pipeline-register enables and clears.

---
 rtl/hazard_unit_mdu_if.sv | 53 +++++
 rtl/hazard_unit_mdu.sv | 100 ++++++++++
 tb/tb_hazard_unit_mdu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mdu_if.sv
// Hazard-unit bus: pipeline status from the datapath in, forwarding selects
// and pipeline enables/clears back out.
interface hazard_unit_mdu_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic [REG_W-1:0] RsE;
    logic [REG_W-1:0] RtE;
    logic [REG_W-1:0] WriteRegE;
    logic [REG_W-1:0] WriteRegM;
    logic [REG_W-1:0] WriteRegW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             MemtoRegM;
    logic             BranchD;
    logic             PCSrcD;
    logic             JumpD;
    logic             MduStartD;
    logic             MduStartE;
    logic             MfhiloD;
    logic             PerfClr;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ForwardAD;
    logic             ForwardBD;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             FlushD;
    logic             MduBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, PCSrcD, JumpD, MduStartD, MduStartE, MfhiloD, PerfClr,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  StallF, StallD, FlushE, FlushD, MduBusy, StallCount
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, PCSrcD, JumpD, MduStartD, MduStartE, MfhiloD, PerfClr,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output StallF, StallD, FlushE, FlushD, MduBusy, StallCount
    );
endinterface

// File: rtl/hazard_unit_mdu.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline with MDU busy
// scoreboard, branch/jump decode flush and a saturating stall-cycle counter.
module hazard_unit_mdu #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst_n,
    hazard_unit_mdu_if.slave hz
);
    localparam int unsigned       MCNT_W    = $clog2(MDU_LAT + 1);
    localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MDU_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic regMatch(input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    logic [MCNT_W-1:0] mcnt;
    logic [CNT_W-1:0]  stallCnt;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic              fwdAD;
    logic              fwdBD;
    logic              mduBusy;
    logic              lwStall;
    logic              brStall;
    logic              mduStall;
    logic              stall;
    logic              flushD;

    assign mduBusy = (mcnt != '0);

    // Execute-stage operand forwarding, M beats W.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (hz.RegWriteM && regMatch(hz.RsE, hz.WriteRegM)) begin
            fwdA = 2'b10;
        end else if (hz.RegWriteW && regMatch(hz.RsE, hz.WriteRegW)) begin
            fwdA = 2'b01;
        end
        if (hz.RegWriteM && regMatch(hz.RtE, hz.WriteRegM)) begin
            fwdB = 2'b10;
        end else if (hz.RegWriteW && regMatch(hz.RtE, hz.WriteRegW)) begin
            fwdB = 2'b01;
        end
    end

    // Stall causes collapse into a single stall; the decode flush waits it out.
    always_comb begin
        fwdAD    = hz.RegWriteM && regMatch(hz.RsD, hz.WriteRegM);
        fwdBD    = hz.RegWriteM && regMatch(hz.RtD, hz.WriteRegM);
        lwStall  = hz.MemtoRegE &&
                   (regMatch(hz.RsD, hz.RtE) || regMatch(hz.RtD, hz.RtE));
        brStall  = hz.BranchD &&
                   ((hz.RegWriteE && (regMatch(hz.RsD, hz.WriteRegE) ||
                                      regMatch(hz.RtD, hz.WriteRegE))) ||
                    (hz.MemtoRegM && (regMatch(hz.RsD, hz.WriteRegM) ||
                                      regMatch(hz.RtD, hz.WriteRegM))));
        mduStall = (hz.MfhiloD || hz.MduStartD) && (mduBusy || hz.MduStartE);
        stall    = rst_n && (lwStall || brStall || mduStall);
        flushD   = rst_n && (hz.PCSrcD || hz.JumpD) && !stall;
    end

    // Cycles left until HI/LO is written; a new issue restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= '0;
        end else if (hz.MduStartE) begin
            mcnt <= MCNT_LOAD;
        end else if (mcnt != '0) begin
            mcnt <= mcnt - MCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (hz.PerfClr) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign hz.ForwardAE  = rst_n ? fwdA : 2'b00;
    assign hz.ForwardBE  = rst_n ? fwdB : 2'b00;
    assign hz.ForwardAD  = rst_n && fwdAD;
    assign hz.ForwardBD  = rst_n && fwdBD;
    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushE     = stall;
    assign hz.FlushD     = flushD;
    assign hz.MduBusy    = mduBusy;
    assign hz.StallCount = stallCnt;
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Scoreboard bench for hazard_unit_mdu: expected output vectors are queued at
// drive time and compared against the DUT a little later in the same cycle.
module tb_hazard_unit_mdu;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 3;

    typedef struct {
        string            name;
        logic [10:0]      v;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    int               nVec  = 0;
    int               nErr  = 0;
    exp_t             sbq[$];
    logic             expStall = 1'b0;
    logic [CNT_W-1:0] modelCnt = '0;

    hazard_unit_mdu_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_unit_mdu #(.REG_W(REG_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // Reference stall counter, driven by the expected stall of each cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelCnt <= '0;
        else if (hz.PerfClr) modelCnt <= '0;
        else if (expStall && modelCnt != '1) modelCnt <= modelCnt + CNT_W'(1);
    end

    always @(posedge clk) begin
        if (rst_n) assert (!(hz.MduStartE && hz.MduBusy))
            else $error("MduStartE issued while MDU still busy");
    end

    function automatic logic [10:0] mkv(input logic [1:0] fae, input logic [1:0] fbe,
                                        input logic fad, input logic fbd,
                                        input logic st, input logic fl, input logic bz);
        return {fae, fbe, fad, fbd, st, st, st, fl, bz};
    endfunction

    function automatic logic [10:0] obsVec();
        return {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
                hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.MduBusy};
    endfunction

    task automatic clearInputs();
        hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
        hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
        hz.BranchD = 1'b0; hz.PCSrcD = 1'b0; hz.JumpD = 1'b0;
        hz.MduStartD = 1'b0; hz.MduStartE = 1'b0; hz.MfhiloD = 1'b0;
        hz.PerfClr = 1'b0;
        expStall = 1'b0;
    endtask

    task automatic push(input string nm, input logic [10:0] v);
        exp_t e;
        e.name = nm; e.v = v; e.cnt = modelCnt;
        sbq.push_back(e);
        expStall = v[3];
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clearInputs();
            if (k < 2) begin
                hz.MemtoRegE = 1'b1; hz.RtE = 5'd5; hz.RsD = 5'd5;
                hz.RsE = 5'd3; hz.WriteRegM = 5'd3; hz.RegWriteM = 1'b1;
                hz.PCSrcD = 1'b1; hz.MduStartE = 1'b1;
            end else begin
                rst_n = 1'b1;
            end
            #1 push($sformatf("reset_%0d", k), mkv(2'b00, 2'b00, 0, 0, 0, 0, 0));
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_forward();
        exp_t e;
        string nm;
        logic [10:0] v;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            clearInputs();
            hz.RsE = 5'd3; hz.RtE = 5'd3; hz.WriteRegM = 5'd3; hz.WriteRegW = 5'd3;
            hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
            case (k)
                0: begin nm = "fwd_m_prio"; v = mkv(2'b10, 2'b10, 0, 0, 0, 0, 0); end
                1: begin hz.RegWriteM = 1'b0; nm = "fwd_w"; v = mkv(2'b01, 2'b01, 0, 0, 0, 0, 0); end
                2: begin hz.RsE = 5'd0; nm = "fwd_rs_zero"; v = mkv(2'b00, 2'b10, 0, 0, 0, 0, 0); end
                3: begin
                    hz.RsD = 5'd4; hz.RtD = 5'd4; hz.WriteRegM = 5'd4;
                    nm = "fwd_decode"; v = mkv(2'b01, 2'b01, 1, 1, 0, 0, 0);
                end
                default: begin
                    hz.RsE = '0; hz.RtE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
                    nm = "fwd_all_zero"; v = mkv(2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
            endcase
            #1 push(nm, v);
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_loaduse();
        exp_t e;
        string nm;
        logic [10:0] v;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clearInputs();
            hz.MemtoRegE = 1'b1;
            case (k)
                0: begin hz.RtE = 5'd5; hz.RsD = 5'd5; nm = "lw_rs"; v = mkv(2'b00, 2'b00, 0, 0, 1, 0, 0); end
                1: begin hz.RtE = 5'd0; hz.RsD = 5'd5; nm = "lw_rte_zero"; v = mkv(2'b00, 2'b00, 0, 0, 0, 0, 0); end
                2: begin nm = "lw_all_zero"; v = mkv(2'b00, 2'b00, 0, 0, 0, 0, 0); end
                default: begin
                    hz.RtE = 5'd6; hz.RtD = 5'd6; hz.RsD = 5'd1;
                    nm = "lw_rt"; v = mkv(2'b00, 2'b00, 0, 0, 1, 0, 0);
                end
            endcase
            #1 push(nm, v);
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        string nm;
        logic [10:0] v;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            clearInputs();
            case (k)
                0: begin
                    hz.BranchD = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7; hz.RtD = 5'd7;
                    hz.PCSrcD = 1'b1; nm = "br_stall_noflush"; v = mkv(2'b00, 2'b00, 0, 0, 1, 0, 0);
                end
                1: begin
                    hz.BranchD = 1'b1; hz.PCSrcD = 1'b1; hz.RtD = 5'd7;
                    nm = "br_flush_retaken"; v = mkv(2'b00, 2'b00, 0, 0, 0, 1, 0);
                end
                2: begin
                    hz.BranchD = 1'b1; hz.MemtoRegM = 1'b1; hz.RegWriteM = 1'b1;
                    hz.WriteRegM = 5'd2; hz.RsD = 5'd2;
                    nm = "br_load_m"; v = mkv(2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
                3: begin hz.JumpD = 1'b1; nm = "jump_flush"; v = mkv(2'b00, 2'b00, 0, 0, 0, 1, 0); end
                4: begin
                    hz.BranchD = 1'b1; hz.RegWriteE = 1'b1; hz.PCSrcD = 1'b1;
                    nm = "br_zero_reg"; v = mkv(2'b00, 2'b00, 0, 0, 0, 1, 0);
                end
                default: begin
                    hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7; hz.RtD = 5'd7;
                    nm = "br_not_branch"; v = mkv(2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
            endcase
            #1 push(nm, v);
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_mdu();
        exp_t e;
        logic st, bz;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            clearInputs();
            st = 1'b0; bz = 1'b0;
            if (k <= 5) hz.MfhiloD = 1'b1;
            if (k == 0 || k == 6) hz.MduStartE = 1'b1;
            if (k == 7) hz.MduStartD = 1'b1;
            if (k <= 4 || k == 7) st = 1'b1;
            if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) bz = 1'b1;
            #1 push($sformatf("mdu_cyc%0d", k), mkv(2'b00, 2'b00, 0, 0, st, 0, bz));
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mdu();
        exp_t e;
        logic st, bz;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            clearInputs();
            hz.MfhiloD = 1'b1;
            if (k == 0) hz.MduStartE = 1'b1;
            if (k == 2) rst_n = 1'b0;
            if (k == 4) rst_n = 1'b1;
            st = (k <= 1);
            bz = (k == 1);
            #1 push($sformatf("mdu_reset_cyc%0d", k), mkv(2'b00, 2'b00, 0, 0, st, 0, bz));
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    task automatic test_counter();
        exp_t e;
        logic st;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            clearInputs();
            st = 1'b0;
            if (k == 0 || k == 11) hz.PerfClr = 1'b1;
            if ((k >= 1 && k <= 11) || k == 13) begin
                hz.MemtoRegE = 1'b1; hz.RtE = 5'd5; hz.RsD = 5'd5;
                st = 1'b1;
            end
            if (k == 13) begin
                hz.BranchD = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd5;
            end
            #1 push($sformatf("cnt_cyc%0d", k), mkv(2'b00, 2'b00, 0, 0, st, 0, 0));
            #1 e = sbq.pop_front();
            nVec++;
            if (obsVec() !== e.v || hz.StallCount !== e.cnt) begin
                nErr++;
                $display("FAIL %s: got %b cnt %0d, expected %b cnt %0d", e.name, obsVec(), hz.StallCount, e.v, e.cnt);
            end
        end
    endtask

    initial begin
        clearInputs();
        #1 rst_n = 1'b0;
        test_reset();
        test_forward();
        test_loaduse();
        test_branch();
        test_mdu();
        test_reset_mdu();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
